hslp_seq_ctrl: RTL and testbench
================================

HSLP_SEQ_CTRL -- requirements
Module: hslp_seq_ctrl

Interface
REQ-001 Parameter: MODE_HI, default 2'd1, mode code driven on pp_mode for the HH and HL partial products.
REQ-002 Parameter: MODE_LO, default 2'd3, mode code driven on pp_mode for the LH and LL partial products.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operand pair present.
REQ-006 Port: in_ready  output  1  block accepts operands.
REQ-007 Port: a  input  8  multiplicand.
REQ-008 Port: b  input  8  multiplier.
REQ-009 Port: pp_a  output  4  nibble to the shared 4x4 approximate unit.
REQ-010 Port: pp_b  output  4  nibble to the shared 4x4 approximate unit.
REQ-011 Port: pp_mode  output  2  approximation mode select for the shared unit.
REQ-012 Port: pp_prod  input  8  combinational product returned by the shared unit in the same cycle.
REQ-013 Port: out_valid  output  1  product available.
REQ-014 Port: out_ready  input  1  consumer accepts product.
REQ-015 Port: prod  output  16  accumulated 8x8 product.

Function
REQ-016 FSM states: IDLE, HH, HL, LH, LL, DONE.
REQ-017 in_ready = 1 only in IDLE; input handshake = in_valid & in_ready.
REQ-018 On handshake: a and b registered, accumulator cleared, IDLE -> HH.
REQ-019 Sequence HH -> HL -> LH -> LL -> DONE, one state per cycle, no stalls.
REQ-020 Nibble drive: HH {a[7:4], b[7:4], MODE_HI}; HL {a[7:4], b[3:0], MODE_HI}; LH {a[3:0], b[7:4], MODE_LO}; LL {a[3:0], b[3:0], MODE_LO}; a and b here are the registered operands.
REQ-021 pp_a, pp_b and pp_mode are 0 in IDLE and DONE.
REQ-022 Each compute state adds pp_prod to the accumulator: HH shifted left 8, HL and LH shifted left 4, LL unshifted; the sum is modulo 2^16.
REQ-023 DONE: out_valid = 1 and prod = accumulator, both held stable until out_ready = 1.
REQ-024 DONE & out_ready -> IDLE; out_valid falls the next cycle; prod retains its last value.
REQ-025 Latency: handshake at cycle N gives out_valid at cycle N+5; throughput is one product per 6 cycles at best.
REQ-026 in_valid asserted while busy is ignored (in_ready = 0); operand changes while busy do not affect the result.

Reset
REQ-027 rst_n low, asynchronously: state = IDLE, accumulator = 0, registered operands = 0, out_valid = 0, prod = 0, in_ready = 1 once released.
REQ-028 Reset mid-operation discards the operation; no out_valid is produced for it.

Configuration
REQ-029 Macro HSLP_ZERO_SKIP_EN defined: on handshake, if a == 0 or b == 0, go directly to DONE with accumulator 0, so out_valid appears at N+1; pp_* outputs stay 0 for that operation.
REQ-030 Macro HSLP_ZERO_SKIP_EN undefined: zero operands take the full HH..LL sequence, so latency is always 5.

Verification
(Bench stub: pp_prod = pp_a * pp_b exact, ignoring pp_mode.)
REQ-031 a=0xFF, b=0xFF, out_ready=1 -> out_valid at N+5, prod=0xFE01; pp_mode observed 1,1,3,3.
REQ-032 a=0x12, b=0x34, out_ready held 0 for 3 cycles -> prod=0x03A8, stable while held; in_ready=0 until one cycle after out_ready rises.
REQ-033 a=0x00, b=0x9C -> prod=0x0000 at N+1 with HSLP_ZERO_SKIP_EN, at N+5 without.
REQ-034 Second in_valid with a=0x55, b=0x55 asserted during state HL of a first operation -> ignored; first result unchanged; second accepted only after IDLE is re-entered, giving prod=0x1C39.
REQ-035 rst_n pulsed low in state LH -> out_valid=0, prod=0, state IDLE immediately; next operation a=0x03, b=0x07 -> prod=0x0015.

Source files
------------

// File: rtl/hslp_seq_ctrl_if.sv
// Operand, partial-product and result bundle for hslp_seq_ctrl.
// The slave modport is the sequencer; the master modport is its environment.
interface hslp_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  pp_a;
   logic [3:0]  pp_b;
   logic [1:0]  pp_mode;
   logic [7:0]  pp_prod;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] prod;

   modport slave (
      input  in_valid, a, b, pp_prod, out_ready,
      output in_ready, pp_a, pp_b, pp_mode, out_valid, prod
   );

   modport master (
      output in_valid, a, b, pp_prod, out_ready,
      input  in_ready, pp_a, pp_b, pp_mode, out_valid, prod
   );
endinterface

// File: rtl/hslp_seq_ctrl.sv
// 8x8 multiply sequenced over one shared 4x4 approximate unit (HH, HL, LH, LL nibble products).
// Optional macro HSLP_ZERO_SKIP_EN: a zero operand jumps straight to DONE with a zero result.
module hslp_seq_ctrl #(
   parameter logic [1:0] MODE_HI = 2'd1,
   parameter logic [1:0] MODE_LO = 2'd3
) (
   input logic clk,
   input logic rst_n,
   hslp_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, HH, HL, LH, LL, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  a_q, b_q;
   logic [15:0] acc_q, acc_d;
   logic [15:0] prod_q;
   logic [3:0]  pp_a, pp_b;
   logic [1:0]  pp_mode;
   logic        handshake;

   assign handshake     = bus.in_valid & (state_q == IDLE);
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.prod      = prod_q;
   assign bus.pp_a      = pp_a;
   assign bus.pp_b      = pp_b;
   assign bus.pp_mode   = pp_mode;

   // Next state, nibble selection and accumulation of the shared unit's product.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pp_a    = 4'h0;
      pp_b    = 4'h0;
      pp_mode = 2'd0;
      case (state_q)
         IDLE: begin
            if (handshake) begin
               acc_d = 16'h0000;
`ifdef HSLP_ZERO_SKIP_EN
               if ((bus.a == 8'h00) || (bus.b == 8'h00))
                  state_d = DONE;
               else
                  state_d = HH;
`else
               state_d = HH;
`endif
            end
         end
         HH: begin
            pp_a    = a_q[7:4];
            pp_b    = b_q[7:4];
            pp_mode = MODE_HI;
            acc_d   = acc_q + {bus.pp_prod, 8'h00};
            state_d = HL;
         end
         HL: begin
            pp_a    = a_q[7:4];
            pp_b    = b_q[3:0];
            pp_mode = MODE_HI;
            acc_d   = acc_q + {4'h0, bus.pp_prod, 4'h0};
            state_d = LH;
         end
         LH: begin
            pp_a    = a_q[3:0];
            pp_b    = b_q[7:4];
            pp_mode = MODE_LO;
            acc_d   = acc_q + {4'h0, bus.pp_prod, 4'h0};
            state_d = LL;
         end
         LL: begin
            pp_a    = a_q[3:0];
            pp_b    = b_q[3:0];
            pp_mode = MODE_LO;
            acc_d   = acc_q + {8'h00, bus.pp_prod};
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // prod is captured on entry to DONE so it survives the next operation's accumulator clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         acc_q   <= 16'h0000;
         prod_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         if (handshake) begin
            a_q <= bus.a;
            b_q <= bus.b;
         end
         if ((state_d == DONE) && (state_q != DONE))
            prod_q <= acc_d;
      end
   end

endmodule

// File: tb/tb_hslp_seq_ctrl.sv
// Randomized bench for hslp_seq_ctrl against an arithmetic reference (exact 4x4 stub, prod = a*b).
module tb_hslp_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   hslp_seq_ctrl_if bus();

   hslp_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.pp_prod = 8'({4'h0, bus.pp_a} * {4'h0, bus.pp_b});

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Step k of the nibble schedule: high a nibble for the first two steps, b alternates high/low.
   function automatic logic [9:0] expPp(input logic [7:0] av, input logic [7:0] bv, input int k);
      logic [3:0] na;
      logic [3:0] nb;
      logic [1:0] md;
      na = (k < 2) ? av[7:4] : av[3:0];
      nb = (k % 2 == 0) ? bv[7:4] : bv[3:0];
      md = (k < 2) ? 2'd1 : 2'd3;
      return {na, nb, md};
   endfunction

   task automatic driveBusy(input bit hammer);
      if (hammer) begin
         bus.in_valid = 1'b1;
         bus.a        = 8'h55;
         bus.b        = 8'h55;
      end else begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.a        = 8'($urandom);
         bus.b        = 8'($urandom);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input int hold,
                                input bit hammer, input string tag);
      int          lat;
      int          expLat;
      logic [15:0] expProd;
      expProd = {8'h00, av} * {8'h00, bv};
      expLat  = 5;
`ifdef HSLP_ZERO_SKIP_EN
      if ((av == 8'h00) || (bv == 8'h00))
         expLat = 1;
`endif
      @(negedge clk);
      bus.a         = av;
      bus.b         = bv;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      lat = 1;
      driveBusy(hammer);
      while (!bus.out_valid && lat < 20) begin
         if (lat <= 4)
            checkOutput($sformatf("%s_pp%0d", tag, lat),
                        32'({bus.pp_a, bus.pp_b, bus.pp_mode}), 32'(expPp(av, bv, lat - 1)));
         @(negedge clk);
         lat++;
         driveBusy(hammer);
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_prod"}, 32'(bus.prod), 32'(expProd));
      checkOutput({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, "_done_pp"}, 32'({bus.pp_a, bus.pp_b, bus.pp_mode}), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         driveBusy(hammer);
         checkOutput($sformatf("%s_hold%0d_prod", tag, i), 32'(bus.prod), 32'(expProd));
         checkOutput($sformatf("%s_hold%0d_valid", tag, i), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("%s_hold%0d_ready", tag, i), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_prod_kept"}, 32'(bus.prod), 32'(expProd));
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      bus.in_valid  = 1'b0;
      bus.a         = 8'h00;
      bus.b         = 8'h00;
      bus.out_ready = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_prod", 32'(bus.prod), 32'd0);
      checkOutput("rst_pp", 32'({bus.pp_a, bus.pp_b, bus.pp_mode}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);

      applyStimulus(8'hFF, 8'hFF, 0, 1'b0, "ff_ff");
      applyStimulus(8'h12, 8'h34, 3, 1'b0, "hold3");
      applyStimulus(8'h00, 8'h9C, 1, 1'b0, "zero_a");
      applyStimulus(8'h12, 8'h34, 0, 1'b1, "busy_in");
      applyStimulus(8'h55, 8'h55, 0, 1'b0, "second");

      // Abort an operation in LH and confirm nothing comes out of it.
      @(negedge clk);
      bus.a        = 8'h12;
      bus.b        = 8'h34;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_rst_lh_pp", 32'({bus.pp_a, bus.pp_b, bus.pp_mode}), 32'(expPp(8'h12, 8'h34, 2)));
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_rst_prod", 32'(bus.prod), 32'd0);
      checkOutput("mid_rst_pp", 32'({bus.pp_a, bus.pp_b, bus.pp_mode}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("post_rst_valid%0d", i), 32'(bus.out_valid), 32'd0);
      end
      applyStimulus(8'h03, 8'h07, 0, 1'b0, "after_rst");

      for (int n = 0; n < 24; n++) begin
         ra = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
